word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: load  input  1  request to serialize in_word, sampled on clk rising edge.
REQ-004 SHALL have port: in_word  input  15  instruction/data word to be written to byte-wide memory.
REQ-005 SHALL have port: base_addr  input  8  memory address of the first byte.
REQ-006 SHALL have port: mem_ready  input  1  memory accepts the current byte on a clk edge where wr_en=1 and mem_ready=1.
REQ-007 SHALL have port: out_byte  output  8  byte presented to memory.
REQ-008 SHALL have port: addr  output  8  address of out_byte.
REQ-009 SHALL have port: wr_en  output  1  out_byte/addr valid, write requested.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the second byte is accepted.
REQ-012 SHALL have port: out_par  output  1  parity of out_byte (see Configuration).

Function
REQ-013 SHALL implement states IDLE, HI, LO, DONE, all registered.
REQ-014 In IDLE with load=1, SHALL latch in_word and base_addr and move to HI on the same edge.
REQ-015 In HI, SHALL drive out_byte={1'b0,word[14:8]}, addr=latched base, wr_en=1.
REQ-016 In LO, SHALL drive out_byte=word[7:0], addr=base+1 (8-bit, modulo 256), wr_en=1.
REQ-017 High byte first: byte order SHALL match the receive-side assembly (first byte ends up in bits 14:8).
REQ-018 In HI or LO with mem_ready=0, SHALL hold state, out_byte, addr, wr_en unchanged (no timeout).
REQ-019 In HI with mem_ready=1, SHALL advance to LO; in LO with mem_ready=1, SHALL advance to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, wr_en=0, busy=1, then return to IDLE.
REQ-021 Minimum latency: load edge to done=1 SHALL be 3 cycles when mem_ready is held high.
REQ-022 load SHALL be ignored while busy=1; the latched word and address SHALL NOT change.
REQ-023 load in the IDLE cycle following DONE SHALL be accepted (back-to-back words, 3 cycles each).
REQ-024 Address wrap: base_addr=8'hFF SHALL give HI addr 8'hFF, LO addr 8'h00.
REQ-025 wr_en, done, busy SHALL be registered outputs, free of combinational paths from inputs.
REQ-026 In IDLE, out_byte and addr SHALL hold their last driven values; wr_en=0.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, force state=IDLE, out_byte=8'h00, addr=8'h00, wr_en=0, busy=0, done=0, out_par=0, latched word=15'h0000.
REQ-028 Reset asserted mid-transfer SHALL abandon the word; no further write is issued after release until a new load.
REQ-029 First load SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro WORD_SERIALIZER_PARITY_EN, when defined, SHALL make out_par the even parity (XOR) of out_byte, registered together with out_byte.
REQ-031 Without WORD_SERIALIZER_PARITY_EN, out_par SHALL be tied to 0 and no parity logic SHALL be synthesized; port list SHALL be identical in both builds.

Verification
REQ-032 Reset then load=1, in_word=15'h5A3C, base_addr=8'h10, mem_ready=1 -> cycle1: out_byte=8'h5A addr=8'h10 wr_en=1; cycle2: out_byte=8'h3C addr=8'h11; cycle3: done=1 wr_en=0.
REQ-033 Same stimulus, mem_ready=0 for 4 cycles in HI -> out_byte=8'h5A, addr=8'h10, wr_en=1 held stable 5 cycles; done on cycle 7.
REQ-034 base_addr=8'hFF, in_word=15'h7FFF -> addr sequence 8'hFF, 8'h00; bytes 8'h7F, 8'hFF.
REQ-035 Second load with in_word=15'h1234 during HI of a transfer -> ignored; original bytes written; 15'h1234 never appears.
REQ-036 rst_n pulsed low during LO -> wr_en=0 and busy=0 immediately (before next clk edge); no done pulse.
REQ-037 With WORD_SERIALIZER_PARITY_EN, in_word=15'h0701 -> out_par=1 for 8'h07, 1 for 8'h01; without macro out_par=0 throughout.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: splits a 15-bit word into two byte writes, high byte first.
// The high byte carries word[14:8] zero-extended, the low byte carries word[7:0].
// Optional feature: define WORD_SERIALIZER_PARITY_EN to drive out_par with the
// XOR of out_byte, registered alongside it. Without it out_par is tied low.
module word_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [14:0] in_word,
    input  logic [7:0]  base_addr,
    input  logic        mem_ready,
    output logic [7:0]  out_byte,
    output logic [7:0]  addr,
    output logic        wr_en,
    output logic        busy,
    output logic        done,
    output logic        out_par
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] word_q, word_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic [7:0]  addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next state and next registered outputs; everything holds unless a
    // transition says otherwise, so a stalled byte stays perfectly stable.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        base_d     = base_q;
        out_byte_d = out_byte_q;
        addr_d     = addr_q;
        wr_en_d    = wr_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                if (load) begin
                    state_d    = HI;
                    word_d     = in_word;
                    base_d     = base_addr;
                    out_byte_d = {1'b0, in_word[14:8]};
                    addr_d     = base_addr;
                    wr_en_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            HI: begin
                if (mem_ready) begin
                    state_d    = LO;
                    out_byte_d = word_q[7:0];
                    addr_d     = base_q + 8'd1;   // wraps 8'hFF -> 8'h00
                    wr_en_d    = 1'b1;
                end
            end
            LO: begin
                if (mem_ready) begin
                    state_d = DONE;
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= 15'h0000;
            base_q     <= 8'h00;
            out_byte_q <= 8'h00;
            addr_q     <= 8'h00;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            base_q     <= base_d;
            out_byte_q <= out_byte_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef WORD_SERIALIZER_PARITY_EN
    logic par_q;

    // Parity is computed from the next byte so it lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= ^out_byte_d;
    end

    assign out_par = par_q;
`else
    assign out_par = 1'b0;
`endif

    assign out_byte = out_byte_q;
    assign addr     = addr_q;
    assign wr_en    = wr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer; parity expectations follow the
// WORD_SERIALIZER_PARITY_EN build setting.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [14:0] in_word;
    logic [7:0]  base_addr;
    logic        mem_ready;
    logic [7:0]  out_byte;
    logic [7:0]  addr;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        out_par;

    int checks   = 0;
    int failures = 0;

    word_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .in_word   (in_word),
        .base_addr (base_addr),
        .mem_ready (mem_ready),
        .out_byte  (out_byte),
        .addr      (addr),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .out_par   (out_par)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full output snapshot; par is the hand-computed parity, masked by build.
    task automatic chk_all(input string tag, input logic [7:0] ob, input logic [7:0] ad,
                           input logic we, input logic bz, input logic dn, input logic par);
        chk({tag, ".out_byte"}, {8'h00, out_byte}, {8'h00, ob});
        chk({tag, ".addr"},     {8'h00, addr},     {8'h00, ad});
        chk({tag, ".wr_en"},    {15'h0, wr_en},    {15'h0, we});
        chk({tag, ".busy"},     {15'h0, busy},     {15'h0, bz});
        chk({tag, ".done"},     {15'h0, done},     {15'h0, dn});
        chk({tag, ".out_par"},  {15'h0, out_par},  {15'h0, par & PAR_EN});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; in_word = '0; base_addr = '0; mem_ready = 1'b1;
        tick(); tick();
        chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic transfer, accepted on the first edge after reset release.
        rst_n = 1'b1; load = 1'b1; in_word = 15'h5A3C; base_addr = 8'h10;
        tick(); load = 1'b0;
        chk_all("basic.hi", 8'h5A, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("basic.lo", 8'h3C, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("basic.done", 8'h3C, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("basic.idle", 8'h3C, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stall in HI for 4 cycles: HI visible 5 cycles, done on cycle 7.
        load = 1'b1; mem_ready = 1'b0;
        tick(); load = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk_all($sformatf("stall.hi%0d", i), 8'h5A, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 5) mem_ready = 1'b1;
            tick();
        end
        chk_all("stall.lo", 8'h3C, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        // Back-to-back: load held through DONE, taken in the following IDLE.
        load = 1'b1; in_word = 15'h7FFF; base_addr = 8'hFF;
        tick();
        chk_all("stall.done", 8'h3C, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("b2b.idle", 8'h3C, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); load = 1'b0;
        chk_all("wrap.hi", 8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("wrap.lo", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("wrap.done", 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        // Load while busy is ignored.
        load = 1'b1; in_word = 15'h5A3C; base_addr = 8'h10;
        tick();
        in_word = 15'h1234; base_addr = 8'h20; mem_ready = 1'b0;
        tick();
        chk_all("ign.hi", 8'h5A, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b1;
        tick();
        chk_all("ign.lo", 8'h3C, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_all("ign.done", 8'h3C, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        // Parity word, then reset asserted asynchronously during LO.
        load = 1'b1; in_word = 15'h0701; base_addr = 8'h40;
        tick(); load = 1'b0;
        chk_all("par.hi", 8'h07, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("par.lo", 8'h01, 8'h41, 1'b1, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.async", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("rst.after%0d", i), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
